pam4_tx: RTL and testbench

Transmit-side symbol source for the equalizer test chain. It generates framed PAM-4 bursts: a fixed alternating preamble followed by PRBS-15 payload symbols, Gray-mapped to signed Q(18,15) levels. Its output stream is the stimulus that feeds the channel model ahead of the CMA FIR receiver. A valid/ready handshake back-pressures it.

---
 rtl/pam4_pkg.sv | 39 +++
 rtl/prbs15_step2.sv | 22 ++
 rtl/pam4_tx.sv | 152 +++++++++++++++
 tb/tb_pam4_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pam4_pkg.sv
// Shared types and constants for the PAM-4 transmit symbol source:
// FSM state encoding, Q(18,15) level constants, Gray mapping and PRBS-15 taps.
package pam4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_PAYLOAD
   } state_t;

   // Levels are expressed in Q(18,15): L3 = 1.0, L1 = round(1/3 * 2^15).
   localparam int NB_LEVEL  = 18;
   localparam int NBF_LEVEL = 15;

   localparam logic signed [NB_LEVEL-1:0] LVL_P3 =  18'sd32768;
   localparam logic signed [NB_LEVEL-1:0] LVL_P1 =  18'sd10923;
   localparam logic signed [NB_LEVEL-1:0] LVL_N1 = -18'sd10923;
   localparam logic signed [NB_LEVEL-1:0] LVL_N3 = -18'sd32768;

   // PRBS-15 (x^15 + x^14 + 1): feedback is s[14] ^ s[13], shifted in at bit 0.
   localparam int PRBS_W     = 15;
   localparam int PRBS_TAP_A = 14;
   localparam int PRBS_TAP_B = 13;

   // Gray map of a symbol's bit pair {b1, b0} to its signed level.
   function automatic logic signed [NB_LEVEL-1:0] gray_map(input logic [1:0] bits);
      logic signed [NB_LEVEL-1:0] level;
      level = LVL_N3;
      case (bits)
         2'b00: level = LVL_N3;
         2'b01: level = LVL_N1;
         2'b11: level = LVL_P1;
         2'b10: level = LVL_P3;
         default: level = LVL_N3;
      endcase
      return level;
   endfunction

endpackage

// File: rtl/prbs15_step2.sv
// Combinational double step of the PRBS-15 generator: produces the two
// emitted bits of one PAM-4 symbol and the LFSR state after both steps.
module prbs15_step2
   import pam4_pkg::*;
(
   input  logic [PRBS_W-1:0] state,
   output logic [PRBS_W-1:0] state_next,
   output logic              b1,
   output logic              b0
);

   logic [PRBS_W-1:0] mid;

   // Two chained LFSR steps; the first emitted bit is the symbol MSB.
   always_comb begin
      b1         = state[PRBS_TAP_A] ^ state[PRBS_TAP_B];
      mid        = {state[PRBS_W-2:0], b1};
      b0         = mid[PRBS_TAP_A] ^ mid[PRBS_TAP_B];
      state_next = {mid[PRBS_W-2:0], b0};
   end

endmodule

// File: rtl/pam4_tx.sv
// Framed PAM-4 burst source: alternating +/-L3 preamble followed by Gray-mapped
// PRBS-15 payload, presented through a registered valid/ready output stage.
module pam4_tx
   import pam4_pkg::*;
#(
   parameter int                NB_OUT       = 18,
   parameter int                NBF_OUT      = 15,
   parameter int                PREAMBLE_LEN = 64,
   parameter logic [PRBS_W-1:0] PRBS_SEED    = 15'h7FFF,
   parameter int                NB_LEN       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_en,
   input  logic                     i_start,
   input  logic [NB_LEN-1:0]        i_burst_len,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic signed [NB_OUT-1:0] o_sample,
   output logic                     o_preamble,
   output logic                     o_last,
   output logic                     o_busy
);

   localparam logic [NB_LEN-1:0] PRE_LAST = NB_LEN'(PREAMBLE_LEN - 1);
   localparam logic [NB_LEN-1:0] ONE      = NB_LEN'(1);

   state_t              state, state_nxt;
   logic [PRBS_W-1:0]   lfsr, lfsr_nxt, lfsr_step;
   logic [NB_LEN-1:0]   cnt, cnt_nxt;        // index of the symbol on the output
   logic [NB_LEN-1:0]   len_q, len_nxt;
   logic                valid_nxt, pre_nxt, last_nxt;
   logic signed [NB_OUT-1:0] sample_nxt;
   logic                b1, b0;
   logic                xfer;

   // Re-align a package level (Q(.,15)) to the output word format.
   function automatic logic signed [NB_OUT-1:0] to_out(input logic signed [NB_LEVEL-1:0] level);
      return NB_OUT'(level) <<< (NBF_OUT - NBF_LEVEL);
   endfunction

   prbs15_step2 u_prbs (
      .state      (lfsr),
      .state_next (lfsr_step),
      .b1         (b1),
      .b0         (b0)
   );

   assign xfer   = o_valid && i_ready && i_en;
   assign o_busy = (state != ST_IDLE);

   // State register; reset wins over enable, disable freezes the state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst)
         state <= ST_IDLE;
      else if (i_en)
         state <= state_nxt;
   end

   // Next-state logic: start from idle, leave preamble/payload on the final transfer.
   always_comb begin
      // NOTE: every comb output gets a default first, otherwise an unassigned path infers a latch.
      state_nxt = state;
      case (state)
         ST_IDLE:     if (i_start)                  state_nxt = ST_PREAMBLE;
         ST_PREAMBLE: if (xfer && cnt == PRE_LAST)  state_nxt = ST_PAYLOAD;
         ST_PAYLOAD:  if (xfer && o_last)           state_nxt = ST_IDLE;
         default:                                   state_nxt = ST_IDLE;
      endcase
   end

   // Output comb: value the output stage loads next (only on start or transfer).
   always_comb begin
      valid_nxt  = o_valid;
      sample_nxt = o_sample;
      pre_nxt    = o_preamble;
      last_nxt   = o_last;
      cnt_nxt    = cnt;
      lfsr_nxt   = lfsr;
      len_nxt    = len_q;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               len_nxt    = i_burst_len;
               lfsr_nxt   = PRBS_SEED;
               cnt_nxt    = '0;
               valid_nxt  = 1'b1;
               sample_nxt = to_out(LVL_P3);
               pre_nxt    = 1'b1;
               last_nxt   = 1'b0;
            end
         end
         ST_PREAMBLE: begin
            if (xfer) begin
               if (cnt == PRE_LAST) begin
                  cnt_nxt    = '0;
                  lfsr_nxt   = lfsr_step;
                  sample_nxt = to_out(gray_map({b1, b0}));
                  pre_nxt    = 1'b0;
                  last_nxt   = (len_q == ONE);
               end else begin
                  cnt_nxt    = cnt + ONE;
                  // Next index has the opposite parity of the current one.
                  sample_nxt = cnt[0] ? to_out(LVL_P3) : to_out(LVL_N3);
               end
            end
         end
         ST_PAYLOAD: begin
            if (xfer) begin
               if (o_last) begin
                  cnt_nxt    = '0;
                  valid_nxt  = 1'b0;
                  sample_nxt = '0;
                  pre_nxt    = 1'b0;
                  last_nxt   = 1'b0;
               end else begin
                  cnt_nxt    = cnt + ONE;
                  lfsr_nxt   = lfsr_step;
                  sample_nxt = to_out(gray_map({b1, b0}));
                  // A latched length of 0 means continuous: never flag a last symbol.
                  last_nxt   = (len_q != '0) && (cnt + ONE == len_q - ONE);
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers; frozen while disabled.
   always_ff @(posedge clk) begin
      // NOTE: the reset is synchronous, and the LFSR resets to the seed rather than zero (all-zero locks it up).
      if (!rst) begin
         lfsr       <= PRBS_SEED;
         cnt        <= '0;
         len_q      <= '0;
         o_valid    <= 1'b0;
         o_sample   <= '0;
         o_preamble <= 1'b0;
         o_last     <= 1'b0;
      end else if (i_en) begin
         lfsr       <= lfsr_nxt;
         cnt        <= cnt_nxt;
         len_q      <= len_nxt;
         o_valid    <= valid_nxt;
         o_sample   <= sample_nxt;
         o_preamble <= pre_nxt;
         o_last     <= last_nxt;
      end
   end

endmodule

// File: tb/tb_pam4_tx.sv
// Self-checking bench for pam4_tx: randomized ready/enable stimulus checked
// against a symbol-list reference model built from the PRBS-15/Gray rules.
module tb_pam4_tx;

   localparam int PRE_LEN = 4;
   localparam int SEED    = 'h7FFF;

   typedef struct {
      int sample;
      bit pre;
      bit last;
   } sym_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               i_en;
   logic               i_start;
   logic [15:0]        i_burst_len;
   logic               i_ready;
   logic               o_valid;
   logic signed [17:0] o_sample;
   logic               o_preamble;
   logic               o_last;
   logic               o_busy;

   int   total = 0;
   int   bad   = 0;
   sym_t exp_q[$];

   pam4_tx #(
      .NB_OUT       (18),
      .NBF_OUT      (15),
      .PREAMBLE_LEN (PRE_LEN),
      .PRBS_SEED    (15'h7FFF),
      .NB_LEN       (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_en        (i_en),
      .i_start     (i_start),
      .i_burst_len (i_burst_len),
      .i_ready     (i_ready),
      .o_valid     (o_valid),
      .o_sample    (o_sample),
      .o_preamble  (o_preamble),
      .o_last      (o_last),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, int'(o_valid), 0);
      check({tag, "_sample"}, int'($signed(o_sample)), 0);
      check({tag, "_pre"}, int'(o_preamble), 0);
      check({tag, "_last"}, int'(o_last), 0);
      check({tag, "_busy"}, int'(o_busy), 0);
   endtask

   function automatic int level_of(input int code);
      case (code)
         0:       return -32768;
         1:       return -10923;
         3:       return  10923;
         default: return  32768;
      endcase
   endfunction

   function automatic void push_sym(input int sample, input bit pre, input bit last);
      sym_t s;
      s.sample = sample;
      s.pre    = pre;
      s.last   = last;
      exp_q.push_back(s);
   endfunction

   // Expected burst: alternating preamble, then n payload symbols from a software PRBS-15.
   function automatic void build_model(input int len, input int n);
      int s, nb, b1;
      exp_q.delete();
      s = SEED;
      for (int k = 0; k < PRE_LEN; k++) push_sym((k % 2 == 0) ? 32768 : -32768, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) begin
         nb = ((s >> 14) ^ (s >> 13)) & 1;
         s  = ((s << 1) | nb) & 'h7FFF;
         b1 = nb;
         nb = ((s >> 14) ^ (s >> 13)) & 1;
         s  = ((s << 1) | nb) & 'h7FFF;
         push_sym(level_of(b1 * 2 + nb), 1'b0, (len != 0) && (i == len - 1));
      end
   endfunction

   // Hand-derived 8-symbol burst from the all-ones seed.
   function automatic void build_hand8();
      exp_q.delete();
      for (int k = 0; k < PRE_LEN; k++) push_sym((k % 2 == 0) ? 32768 : -32768, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) push_sym(-32768, 1'b0, 1'b0);
      push_sym(32768, 1'b0, 1'b1);
   endfunction

   // Issue a start pulse; returns at the observation point of symbol 0.
   task automatic start_burst(input int len);
      i_en        = 1'b1;
      i_burst_len = 16'(len);
      i_start     = 1'b1;
      @(posedge clk); #1;
      i_start     = 1'b0;
      i_burst_len = 16'($urandom);
   endtask

   // Drive ready/enable and compare every presented symbol with the model head.
   task automatic run(input int n_xfer, input int ready_pct, input int drop_at,
                      input int poke_at, input bit end_chk);
      int   xfers  = 0;
      int   cyc    = 0;
      int   en_low = 0;
      bit   dropped = 1'b0;
      bit   poked   = 1'b0;
      sym_t h;
      while (xfers < n_xfer && cyc < n_xfer * 20 + 100) begin
         i_start = 1'b0;
         check("valid", int'(o_valid), 1);
         check("busy", int'(o_busy), 1);
         if (exp_q.size() == 0) begin
            check("model_empty", 1, 0);
            break;
         end
         h = exp_q[0];
         check("sample", int'($signed(o_sample)), h.sample);
         check("pre", int'(o_preamble), int'(h.pre));
         check("last", int'(o_last), int'(h.last));
         if (!dropped && drop_at >= 0 && xfers == drop_at) begin
            dropped = 1'b1;
            en_low  = 5;
         end
         if (en_low > 0) begin
            i_en    = 1'b0;
            i_ready = 1'b1;
            en_low--;
         end else begin
            i_en    = 1'b1;
            i_ready = ($urandom_range(99) < ready_pct);
         end
         if (!poked && poke_at >= 0 && xfers == poke_at) begin
            poked       = 1'b1;
            i_start     = 1'b1;
            i_burst_len = 16'($urandom_range(1, 5));
         end
         if (i_ready && i_en) begin
            void'(exp_q.pop_front());
            xfers++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      i_start = 1'b0;
      i_en    = 1'b1;
      check("xfer_count", xfers, n_xfer);
      if (end_chk) check_idle("end");
   endtask

   initial begin
      rst         = 1'b0;
      i_en        = 1'b1;
      i_start     = 1'b0;
      i_ready     = 1'b0;
      i_burst_len = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      rst = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         check_idle("idle");
      end

      // Start while disabled is ignored.
      i_en = 1'b0; i_start = 1'b1; i_burst_len = 16'd8;
      @(posedge clk); #1;
      i_start = 1'b0; i_en = 1'b1;
      check_idle("dis_start");

      // Preamble and the hand-derived 8-symbol payload, ready held high.
      build_hand8();
      start_burst(8);
      run(PRE_LEN + 8, 100, -1, -1, 1'b1);

      // Long burst against the model, full throughput.
      build_model(1000, 1000);
      start_burst(1000);
      run(PRE_LEN + 1000, 100, -1, -1, 1'b1);

      // Same burst with back-pressure, an enable drop and a stray start pulse.
      build_model(1000, 1000);
      start_burst(1000);
      run(PRE_LEN + 1000, 60, 300, 500, 1'b1);

      // Continuous mode: no o_last within 5000 symbols.
      build_model(0, 5000);
      start_burst(0);
      run(PRE_LEN + 5000 - 10, 100, -1, 2000, 1'b0);

      // Reset mid-payload, then the seed sequence must repeat.
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle("midrst");
      rst = 1'b1;
      build_model(1000, 1000);
      start_burst(1000);
      run(PRE_LEN + 1000, 75, 50, 120, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
